shift_register_multimode: RTL and testbench

Parametrised multi-mode shift register for the sequential multiplier datapath and its successors (divider, normaliser). It supports the following operations:
- Parallel load.
- Multi-step shifts of a programmable amount, executed one bit per clock under an FSM.
- Four shift modes: logical left, logical right, arithmetic right, rotate right.
- A start/busy/done handshake, so a controller can issue a whole shift operation and wait for completion.

---
 rtl/shift_register_multimode.sv | 136 +++++++++++++
 tb/tb_shift_register_multimode.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_multimode.sv
// Multi-mode shift register with parallel load and a start/busy/done handshake.
// A shift operation executes one bit per clock until the latched amount is used up.
module shift_register_multimode #(
   parameter int WORD_LENGTH = 8,
   parameter int AMT_WIDTH   = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic                   start,
   input  logic [1:0]             mode,
   input  logic [AMT_WIDTH-1:0]   amount,
   input  logic                   serial_in,
   input  logic [WORD_LENGTH-1:0] parallel_in,
   output logic [WORD_LENGTH-1:0] parallel_out,
   output logic                   serial_out,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      MODE_LSL = 2'b00,
      MODE_LSR = 2'b01,
      MODE_ASR = 2'b10,
      MODE_ROR = 2'b11
   } shift_mode_t;

   state_t                 state_q, state_d;
   shift_mode_t            mode_q, mode_d;
   logic [AMT_WIDTH-1:0]   count_q, count_d;
   logic [WORD_LENGTH-1:0] data_q, data_d;
   logic                   serial_out_q, serial_out_d;

   logic [WORD_LENGTH-1:0] shift_data;
   logic                   shift_bit;

   // One single-bit step of the latched mode applied to the current contents.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      shift_data = data_q;
      shift_bit  = 1'b0;
      unique case (mode_q)
         MODE_LSL: begin
            shift_data = {data_q[WORD_LENGTH-2:0], serial_in};
            shift_bit  = data_q[WORD_LENGTH-1];
         end
         MODE_LSR: begin
            shift_data = {serial_in, data_q[WORD_LENGTH-1:1]};
            shift_bit  = data_q[0];
         end
         MODE_ASR: begin
            shift_data = {data_q[WORD_LENGTH-1], data_q[WORD_LENGTH-1:1]};
            shift_bit  = data_q[0];
         end
         MODE_ROR: begin
            shift_data = {data_q[0], data_q[WORD_LENGTH-1:1]};
            shift_bit  = data_q[0];
         end
         default: begin
            shift_data = data_q;
            shift_bit  = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      count_d      = count_q;
      data_d       = data_q;
      serial_out_d = serial_out_q;

      unique case (state_q)
         ST_IDLE: begin
            // Load has priority over start when both arrive together.
            if (load) begin
               data_d = parallel_in;
            end else if (start) begin
               if (amount == '0) begin
                  state_d = ST_DONE;
               end else begin
                  mode_d  = shift_mode_t'(mode);
                  count_d = amount;
                  state_d = ST_SHIFT;
               end
            end
         end

         ST_SHIFT: begin
            data_d       = shift_data;
            serial_out_d = shift_bit;
            count_d      = count_q - AMT_WIDTH'(1);
            if (count_q == AMT_WIDTH'(1)) begin
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         mode_q       <= MODE_LSL;
         count_q      <= '0;
         data_q       <= '0;
         serial_out_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
         state_q      <= state_d;
         mode_q       <= mode_d;
         count_q      <= count_d;
         data_q       <= data_d;
         serial_out_q <= serial_out_d;
      end
   end

   assign parallel_out = data_q;
   assign serial_out   = serial_out_q;
   assign busy         = (state_q == ST_SHIFT);
   assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_register_multimode.sv
// Self-checking bench for shift_register_multimode: directed test-plan steps plus
// randomized operations compared against a word-level reference model.
module tb_shift_register_multimode;

   localparam int W  = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          load;
   logic          start;
   logic [1:0]    mode;
   logic [AW-1:0] amount;
   logic          serial_in;
   logic [W-1:0]  parallel_in;
   logic [W-1:0]  parallel_out;
   logic          serial_out;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int unsigned exp_reg = 0;
   int unsigned exp_so  = 0;

   shift_register_multimode #(.WORD_LENGTH(W), .AMT_WIDTH(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .load         (load),
      .start        (start),
      .mode         (mode),
      .amount       (amount),
      .serial_in    (serial_in),
      .parallel_in  (parallel_in),
      .parallel_out (parallel_out),
      .serial_out   (serial_out),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One single-bit shift on the word value, expressed arithmetically.
   task automatic model_shift(input int m, input int unsigned sin);
      int unsigned mask = (1 << W) - 1;
      int unsigned r    = exp_reg;
      case (m)
         0: begin exp_so = (r >> (W - 1)) & 1; exp_reg = ((r << 1) | sin) & mask; end
         1: begin exp_so = r & 1; exp_reg = (r >> 1) | (sin << (W - 1)); end
         2: begin exp_so = r & 1; exp_reg = (r >> 1) | (r & (1 << (W - 1))); end
         default: begin exp_so = r & 1; exp_reg = (r >> 1) | ((r & 1) << (W - 1)); end
      endcase
   endtask

   task automatic check_outputs(input string tag, input int exp_busy, input int exp_done);
      check({tag, ".pout"}, 32'(parallel_out), exp_reg);
      check({tag, ".sout"}, 32'(serial_out), exp_so);
      check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
      check({tag, ".done"}, 32'(done), 32'(exp_done));
   endtask

   task automatic idle_inputs();
      load = 1'b0; start = 1'b0; mode = 2'b00; amount = '0;
      serial_in = 1'b0; parallel_in = '0;
   endtask

   task automatic do_load(input logic [W-1:0] v);
      load = 1'b1; parallel_in = v;
      step();
      load = 1'b0;
      exp_reg = v;
      check_outputs("load", 0, 0);
   endtask

   // sin_sel: 0/1 fixed serial_in, 2 random. junk: 0 quiet, 1 random control noise, 2 fixed noise.
   task automatic run_op(input string tag, input int m, input int amt, input int sin_sel, input int junk);
      int unsigned sin;
      start = 1'b1; load = 1'b0; mode = 2'(m); amount = AW'(amt);
      step();
      start = 1'b0;
      if (amt == 0) begin
         check_outputs({tag, ".zero"}, 0, 1);
      end else begin
         check_outputs({tag, ".e0"}, 1, 0);
         for (int i = 1; i <= amt; i++) begin
            sin = (sin_sel == 2) ? ($urandom & 1) : 32'(sin_sel);
            serial_in = sin[0];
            if (junk == 1) begin
               load = 1'($urandom); start = 1'($urandom); mode = 2'($urandom);
               amount = AW'($urandom); parallel_in = W'($urandom);
            end else if (junk == 2) begin
               load = 1'b1; parallel_in = '1; start = 1'b1; mode = 2'b11;
            end
            step();
            model_shift(m, sin);
            check_outputs($sformatf("%s.s%0d", tag, i), (i < amt) ? 1 : 0, (i < amt) ? 0 : 1);
         end
      end
      idle_inputs();
      step();
      check_outputs({tag, ".after"}, 0, 0);
   endtask

   initial begin
      // 1. Reset with random inputs
      reset = 1'b0;
      load = 1'($urandom); start = 1'($urandom); mode = 2'($urandom);
      amount = AW'($urandom); serial_in = 1'($urandom); parallel_in = W'($urandom);
      repeat (3) step();
      check_outputs("rst", 0, 0);
      idle_inputs();
      @(negedge clk);
      reset = 1'b1;
      step();
      check_outputs("rst_rel", 0, 0);

      // Reset in the middle of a 5-step shift, after 2 shifts
      do_load(8'hA5);
      start = 1'b1; mode = 2'b00; amount = AW'(5);
      step();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         serial_in = 1'b1;
         step();
         model_shift(0, 1);
      end
      check_outputs("mid_pre", 1, 0);
      #2 reset = 1'b0;
      #1;
      exp_reg = 0; exp_so = 0;
      check_outputs("mid_rst", 0, 0);
      @(negedge clk);
      reset = 1'b1;
      do_load(8'h3C);
      run_op("post_rst", 1, 3, 2, 0);

      // 2. Logical left by 3 with serial_in=1
      do_load(8'hB4);
      run_op("lsl3", 0, 3, 1, 0);
      check("lsl3.final", 32'(parallel_out), 32'h0000_00A7);
      check("lsl3.so", 32'(serial_out), 32'd1);

      // 3. Arithmetic right by 2, then logical right by 4 with zeros
      do_load(8'h96);
      run_op("asr2", 2, 2, 0, 0);
      check("asr2.final", 32'(parallel_out), 32'h0000_00E5);
      run_op("lsr4", 1, 4, 0, 0);
      check("lsr4.final", 32'(parallel_out), 32'h0000_000E);
      check("lsr4.so", 32'(serial_out), 32'd0);

      // 4. Rotate beyond the word width and by exactly the width
      do_load(8'h81);
      run_op("ror9", 3, 9, 2, 0);
      check("ror9.final", 32'(parallel_out), 32'h0000_00C0);
      do_load(8'h81);
      run_op("ror8", 3, 8, 2, 0);
      check("ror8.final", 32'(parallel_out), 32'h0000_0081);

      // 5. Zero amount, then simultaneous load and start
      do_load(8'h5A);
      run_op("amt0", 0, 0, 0, 0);
      check("amt0.final", 32'(parallel_out), 32'h0000_005A);
      load = 1'b1; start = 1'b1; amount = AW'(3); parallel_in = 8'h3C;
      step();
      idle_inputs();
      exp_reg = 32'h3C;
      check_outputs("ldst", 0, 0);
      step();
      check_outputs("ldst2", 0, 0);

      // 6. Control inputs ignored during SHIFT; next start accepted right after done
      do_load(8'h01);
      run_op("ign", 0, 4, 0, 2);
      check("ign.final", 32'(parallel_out), 32'h0000_0010);
      run_op("ign_next", 2, 1, 0, 0);

      // Randomized operations, including saturating amounts and control noise
      for (int k = 0; k < 25; k++) begin
         do_load(W'($urandom));
         run_op($sformatf("rnd%0d", k), int'($urandom_range(0, 3)),
                int'($urandom_range(0, (1 << AW) - 1)), 2, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: observed no completion, expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
